// File: rtl/fe_de_inst_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fe_de_inst_queue_pkg
//  Brief    : Shared FE->DE latch widths, layout helpers and queue defaults.
//  Revision : 1.0 - initial release
// ============================================================================
package fe_de_inst_queue_pkg;

    localparam int c_DBITS             = 32;
    localparam int c_INSTBITS          = 32;
    localparam int c_INSTSIZE          = 4;
    localparam int c_DEPTH             = 4;
    localparam int c_PTRBITS           = 2;
    localparam int c_FROM_DE_TO_FE_WIDTH = 1;
    localparam int c_FE_LATCH_WIDTH    = 1 + c_INSTBITS + 3 * c_DBITS;

    // FE latch layout, MSB->LSB: {valid, inst, PC, pcplus, inst_count}
    function automatic int fe_entry_width(input int dbits, input int instbits);
        return instbits + 3 * dbits;
    endfunction

    function automatic int fe_inst_lsb(input int dbits);
        return 3 * dbits;
    endfunction

    function automatic int fe_pc_lsb(input int dbits);
        return 2 * dbits;
    endfunction

    function automatic int fe_pcplus_lsb(input int dbits);
        return dbits;
    endfunction

endpackage : fe_de_inst_queue_pkg
`default_nettype wire

// File: rtl/fe_de_inst_queue_fifo_ram.sv
`default_nettype none
// ============================================================================
//  Module   : fe_de_inst_queue_fifo_ram
//  Brief    : DEPTH x WIDTH register array, one write port, async read port.
//  Revision : 1.0 - initial release
// ============================================================================
module fe_de_inst_queue_fifo_ram #(
    parameter int DEPTH   = 4,
    parameter int PTRBITS = 2,
    parameter int WIDTH   = 128
) (
    input  logic               clk,
    input  logic               wr_en_i,
    input  logic [PTRBITS-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]   wr_data_i,
    input  logic [PTRBITS-1:0] rd_addr_i,
    output logic [WIDTH-1:0]   rd_data_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Storage is intentionally unreset; occupancy qualifies every read.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule : fe_de_inst_queue_fifo_ram
`default_nettype wire

// File: rtl/fe_de_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fe_de_inst_queue
//  Brief    : FE->DE instruction queue with backpressure and AGEX flush.
//  Revision : 1.0 - initial release
// ============================================================================
module fe_de_inst_queue
    import fe_de_inst_queue_pkg::*;
#(
    parameter int DBITS    = c_DBITS,
    parameter int INSTBITS = c_INSTBITS,
    parameter int DEPTH    = c_DEPTH,
    parameter int PTRBITS  = c_PTRBITS
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [INSTBITS+3*DBITS:0]     fe_latch_in,
    input  logic                          branch_cond,
    output logic                          stall_pipe_FE,
    input  logic                          de_take,
    output logic                          de_valid,
    output logic [INSTBITS-1:0]           de_inst,
    output logic [DBITS-1:0]              de_pc,
    output logic [DBITS-1:0]              de_pcplus,
    output logic [DBITS-1:0]              de_inst_count,
    output logic [PTRBITS:0]              occupancy,
    output logic [DBITS-1:0]              stall_cycles
);

    localparam int            ENTRY_W    = fe_entry_width(DBITS, INSTBITS);
    localparam int            INST_LSB   = fe_inst_lsb(DBITS);
    localparam int            PC_LSB     = fe_pc_lsb(DBITS);
    localparam int            PCPLUS_LSB = fe_pcplus_lsb(DBITS);
    localparam logic [PTRBITS:0] c_FULL  = (PTRBITS + 1)'(DEPTH);

    logic [PTRBITS-1:0] head_q, head_d;
    logic [PTRBITS-1:0] tail_q, tail_d;
    logic [PTRBITS:0]   count_q, count_d;
    logic [DBITS-1:0]   stall_cnt_q, stall_cnt_d;

    logic               w_fe_valid;
    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_rd_entry;
    logic [ENTRY_W-1:0] w_head_entry;

    assign w_fe_valid    = fe_latch_in[ENTRY_W];
    assign stall_pipe_FE = (count_q == c_FULL);
    assign de_valid      = (count_q != '0);
    assign w_push        = w_fe_valid && !stall_pipe_FE && !branch_cond;
    assign w_pop         = de_take && de_valid && !branch_cond;

    always_comb begin
        head_d      = head_q;
        tail_d      = tail_q;
        count_d     = count_q;
        stall_cnt_d = stall_cnt_q;
        if (stall_pipe_FE && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + DBITS'(1);
        end
        // Flush wins over any push/pop in the same cycle.
        if (branch_cond) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_push) tail_d = tail_q + PTRBITS'(1);
            if (w_pop)  head_d = head_q + PTRBITS'(1);
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + (PTRBITS + 1)'(1);
                2'b01:   count_d = count_q - (PTRBITS + 1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    fe_de_inst_queue_fifo_ram #(
        .DEPTH   (DEPTH),
        .PTRBITS (PTRBITS),
        .WIDTH   (ENTRY_W)
    ) u_fifo_ram (
        .clk       (clk),
        .wr_en_i   (w_push),
        .wr_addr_i (tail_q),
        .wr_data_i (fe_latch_in[ENTRY_W-1:0]),
        .rd_addr_i (head_q),
        .rd_data_o (w_rd_entry)
    );

    // Head outputs read as zero whenever the queue is empty.
    assign w_head_entry  = de_valid ? w_rd_entry : '0;
    assign de_inst       = w_head_entry[INST_LSB +: INSTBITS];
    assign de_pc         = w_head_entry[PC_LSB +: DBITS];
    assign de_pcplus     = w_head_entry[PCPLUS_LSB +: DBITS];
    assign de_inst_count = w_head_entry[0 +: DBITS];
    assign occupancy     = count_q;
    assign stall_cycles  = stall_cnt_q;

endmodule : fe_de_inst_queue
`default_nettype wire

// File: tb/tb_fe_de_inst_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fe_de_inst_queue
//  Brief    : Self-checking bench for fe_de_inst_queue against a queue model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fe_de_inst_queue;

    localparam int DBITS    = 32;
    localparam int INSTBITS = 32;
    localparam int DEPTH    = 4;
    localparam int PTRBITS  = 2;
    localparam int LW       = 1 + INSTBITS + 3 * DBITS;

    logic               clk = 1'b0;
    logic               reset;
    logic [LW-1:0]      fe_latch_in;
    logic               branch_cond;
    logic               de_take;
    logic               stall_pipe_FE;
    logic               de_valid;
    logic [INSTBITS-1:0] de_inst;
    logic [DBITS-1:0]   de_pc;
    logic [DBITS-1:0]   de_pcplus;
    logic [DBITS-1:0]   de_inst_count;
    logic [PTRBITS:0]   occupancy;
    logic [DBITS-1:0]   stall_cycles;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pcplus;
        logic [31:0] cnt;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_stall;
    logic        in_valid;
    ent_t        in_e;
    int          n_checks;
    int          n_fail;
    int          seen_210;

    always #5 clk = ~clk;

    fe_de_inst_queue dut (
        .clk           (clk),
        .reset         (reset),
        .fe_latch_in   (fe_latch_in),
        .branch_cond   (branch_cond),
        .stall_pipe_FE (stall_pipe_FE),
        .de_take       (de_take),
        .de_valid      (de_valid),
        .de_inst       (de_inst),
        .de_pc         (de_pc),
        .de_pcplus     (de_pcplus),
        .de_inst_count (de_inst_count),
        .occupancy     (occupancy),
        .stall_cycles  (stall_cycles)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Instruction word and debug count derive from PC, so re-driving a PC holds the latch.
    task automatic drive(input logic v, input logic [31:0] pc, input logic take, input logic br);
        in_valid    = v;
        in_e.pc     = pc;
        in_e.pcplus = pc + 32'd4;
        in_e.inst   = {pc[15:0], ~pc[15:0]};
        in_e.cnt    = pc >> 2;
        fe_latch_in = {v, in_e.inst, in_e.pc, in_e.pcplus, in_e.cnt};
        de_take     = take;
        branch_cond = br;
    endtask

    task automatic compare_outputs(input string ph);
        ent_t h;
        h = '{inst: 32'd0, pc: 32'd0, pcplus: 32'd0, cnt: 32'd0};
        if (mq.size() != 0) h = mq[0];
        check({ph, ".occupancy"}, 64'(occupancy), 64'(mq.size()));
        check({ph, ".de_valid"}, 64'(de_valid), 64'(mq.size() != 0));
        check({ph, ".de_pc"}, 64'(de_pc), 64'(h.pc));
        check({ph, ".de_inst"}, 64'(de_inst), 64'(h.inst));
        check({ph, ".de_pcplus"}, 64'(de_pcplus), 64'(h.pcplus));
        check({ph, ".de_inst_count"}, 64'(de_inst_count), 64'(h.cnt));
        check({ph, ".stall"}, 64'(stall_pipe_FE), 64'(mq.size() == DEPTH));
        check({ph, ".stall_cycles"}, 64'(stall_cycles), 64'(m_stall));
    endtask

    // One clock: check stall pre-edge, advance model on the edge, check all outputs after.
    task automatic step(input string ph);
        bit full;
        full = (mq.size() == DEPTH);
        check({ph, ".stall_pre"}, 64'(stall_pipe_FE), 64'(full));
        @(posedge clk);
        if (full && m_stall != 32'hFFFF_FFFF) m_stall++;
        if (branch_cond) begin
            mq.delete();
        end else begin
            if (de_take && mq.size() != 0) begin
                if (mq[0].pc == 32'h210) seen_210++;
                void'(mq.pop_front());
            end
            if (in_valid && !full) mq.push_back(in_e);
        end
        #1;
        compare_outputs(ph);
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        seen_210 = 0;
        m_stall  = '0;
        reset    = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #12;
        compare_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // Stream three entries with no consumption.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0);
            step("stream");
        end
        check("stream.occ3", 64'(occupancy), 64'd3);
        check("stream.head", 64'(de_pc), 64'h200);

        // Fill, hold 0x210 against the stall, then one take frees a slot.
        drive(1'b1, 32'h20C, 1'b0, 1'b0);
        step("fill");
        check("fill.stall", 64'(stall_pipe_FE), 64'd1);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h210, 1'b0, 1'b0);
            step("hold");
        end
        drive(1'b1, 32'h210, 1'b1, 1'b0);
        step("hold_take");
        drive(1'b1, 32'h210, 1'b0, 1'b0);
        step("hold_accept");
        check("hold.stall_cycles", 64'(stall_cycles), 64'd4);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 32'h0, 1'b1, 1'b0);
            step("drain");
        end
        check("drain.seen_210", 64'(seen_210), 64'd1);
        check("drain.empty", 64'(de_valid), 64'd0);

        // Steady push+pop at occupancy 2 across two pointer wraps.
        drive(1'b1, 32'h2F8, 1'b0, 1'b0);
        step("pp_pre");
        drive(1'b1, 32'h2FC, 1'b0, 1'b0);
        step("pp_pre");
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'h300 + 32'(4 * i), 1'b1, 1'b0);
            step("pushpop");
            check("pushpop.occ2", 64'(occupancy), 64'd2);
        end
        check("pushpop.head", 64'(de_pc), 64'h318);

        // Flush with push and take in the same cycle.
        drive(1'b1, 32'h320, 1'b0, 1'b0);
        step("pre_flush");
        drive(1'b1, 32'h400, 1'b1, 1'b1);
        step("flush");
        check("flush.occ", 64'(occupancy), 64'd0);
        check("flush.valid", 64'(de_valid), 64'd0);
        drive(1'b1, 32'h500, 1'b0, 1'b0);
        step("redirect");
        check("redirect.pc", 64'(de_pc), 64'h500);

        // Bubbles never enqueue.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 32'h600 + 32'(4 * i), 1'b0, 1'b0);
            step("bubble");
        end
        check("bubble.occ", 64'(occupancy), 64'd1);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), {$urandom_range(0, 16'hFFFF), 2'b00},
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0));
            step("rand");
        end

        // Fill to DEPTH, then assert reset mid-cycle.
        drive(1'b0, 32'h0, 1'b0, 1'b1);
        step("pre_arst");
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, 32'h700 + 32'(4 * i), 1'b0, 1'b0);
            step("arst_fill");
        end
        check("arst.full", 64'(occupancy), 64'd4);
        #2;
        reset = 1'b0;
        #1;
        mq.delete();
        m_stall = '0;
        compare_outputs("arst");
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        step("post_arst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fe_de_inst_queue
`default_nettype wire

// File: doc/fe_de_inst_queue.md
Name: fe_de_inst_queue

Overview:
- Receiving end of the FE→DE pipeline latch: sits between FE_STAGE's FE latch output and the DE stage.
- Buffers fetched instruction bundles in a small circular FIFO and presents the head entry to decode.
- Generates the stall_pipe_FE backpressure that FE consumes through from_DE_to_FE.
- Discards all buffered and incoming entries on an AGEX redirect (branch_cond).

Parameters:
- DBITS, 32, data/PC/inst_count width.
- INSTBITS, 32, instruction width.
- DEPTH, 4, queue entries; power of 2, minimum 2.
- PTRBITS, 2, log2(DEPTH).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- fe_latch_in  in  1+INSTBITS+3*DBITS  FE latch, packed MSB→LSB as {valid, inst, PC, pcplus, inst_count}.
- branch_cond  in  1  AGEX redirect/flush, same signal FE receives.
- stall_pipe_FE  out  1  backpressure to FE.
- de_take  in  1  DE consumes the head entry this cycle.
- de_valid  out  1  head entry present.
- de_inst  out  INSTBITS  head instruction.
- de_pc  out  DBITS  head PC.
- de_pcplus  out  DBITS  head PC+INSTSIZE.
- de_inst_count  out  DBITS  head debug instruction count.
- occupancy  out  PTRBITS+1  current entry count.
- stall_cycles  out  DBITS  saturating count of cycles with stall_pipe_FE high.

Behaviour:
- Reset (reset low, asynchronous):
  - head, tail, occupancy and stall_cycles are 0.
  - de_valid and stall_pipe_FE are 0.
  - Head data outputs are 0; storage contents don't care.
- Handshake, FE side:
  - stall_pipe_FE = (occupancy == DEPTH), combinational from registered count only. It has no path from de_take or fe_latch_in.
  - push = fe_valid && !stall_pipe_FE && !branch_cond.
  - Entries with valid=0 (bubbles, including FE's flush-zeroed latch) are never enqueued.
  - FE holds its latch while stall_pipe_FE is high, so a held entry is accepted exactly once: on the edge where stall is low.
- Handshake, DE side:
  - pop = de_take && de_valid && !branch_cond.
  - de_take while empty is ignored; no underflow.
- Latency:
  - An entry pushed at edge N is visible on de_* after edge N; no combinational bypass, minimum latency 1 cycle.
  - de_* are driven from the storage entry at head; de_valid = (occupancy != 0).
- Pointers and count:
  - Pointers wrap modulo DEPTH via natural PTRBITS overflow.
  - occupancy: +1 on push only, -1 on pop only, unchanged on push+pop.
  - Push and pop in the same cycle is legal whenever 0 < occupancy < DEPTH.
  - When full, push is blocked even if pop occurs; FE sees the stall drop the following cycle.
- Flush (branch_cond high at an edge):
  - head, tail and occupancy are cleared to 0; de_valid is low next cycle.
  - The incoming entry and de_take are both ignored.
  - Flush has priority over all other events.
  - Flush does not clear stall_cycles.
- stall_cycles: increments each cycle stall_pipe_FE is high; saturates at all-ones.
- Reset asserted mid-operation clears everything immediately, independent of clk; deassertion is synchronized externally.

Decomposition:
- Shared definitions (DBITS, INSTBITS, INSTSIZE, FE_latch_WIDTH and field offsets for unpacking the FE latch) belong in define.vh.
- Also add from_DE_to_FE_WIDTH = 1 there, so stall_pipe_FE maps directly onto from_DE_to_FE.
- One natural sub-module: fifo_ram, a DEPTH × (INSTBITS+3*DBITS) register array with one write port and one asynchronous read port.
- Pointer, count, flush and stall logic stay in fe_de_inst_queue.

Test Plan:
- Reset then stream: push PCs 0x200, 0x204, 0x208 with de_take=0 → after the third edge, occupancy=3, de_pc=0x200, stall_pipe_FE=0.
- Fill to DEPTH=4 with de_take=0 → stall_pipe_FE=1. Hold the latch (PC 0x210) for 3 cycles, then de_take=1 for one cycle → the 0x210 entry is enqueued exactly once. Draining yields 0x200, 0x204, 0x208, 0x20C, 0x210; stall_cycles=4.
- Simultaneous push+pop at occupancy 2 for 8 cycles with PCs 0x300..0x31C → occupancy stays 2, pointers wrap twice, and DE sees PCs in order with no loss or duplication.
- Flush with occupancy 3, fe_valid=1 (PC 0x400) and de_take=1 all in the same cycle → next cycle occupancy=0, de_valid=0, and 0x400 is not enqueued. A later push of target 0x500 appears at de_pc=0x500.
- Bubble input: fe_latch_in with valid=0 for 5 cycles → occupancy unchanged and de_valid unchanged.
- Assert reset asynchronously mid-cycle with occupancy 4 → all outputs are 0 before the next clk edge; stall_cycles=0.
